// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing front end for the pipelined unsigned multiplier IP.
// Accepts MULT/MULTU requests and converts signed operands to magnitudes.
// Holds the IP inputs for LATENCY cycles, then captures the product and
// re-applies its sign. Stalls the pipeline while busy and honours flush.
// LATENCY must be at least 1.
module mult_ctrl #(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [DATA_W-1:0]     op1,
   input  logic [DATA_W-1:0]     op2,
   input  logic                  flush,
   output logic [DATA_W-1:0]     ip_a,
   output logic [DATA_W-1:0]     ip_b,
   input  logic [2*DATA_W-1:0]   ip_p,
   output logic                  stall_req,
   output logic [2*DATA_W-1:0]   result,
   output logic                  result_valid
);

   // Counter must hold LATENCY+1; the WAIT phase spans LATENCY+1 cycles.
   localparam int CNT_W = $clog2(LATENCY + 2);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg;
   logic               accept;
   logic               capture;

   // Two's complement magnitude; the most negative value maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic sgn);
      logic signed [DATA_W-1:0] sv;
      sv = v;
      if (sgn && (sv < 0))
         return DATA_W'(-sv);
      else
         return v;
   endfunction

   // Re-apply the product sign modulo 2^(2*DATA_W).
   function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] p,
                                                      input logic n);
      if (n)
         return ~p + (2*DATA_W)'(1);
      else
         return p;
   endfunction

   // Accept/capture qualifiers; flush overrides both.
   always_comb begin
      accept  = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
      capture = (state_q == WAIT) && (cnt_q == CNT_ONE) && !flush;
   end

   // Control state and latency counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic, stall and strobe outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall_req    = (state_q == WAIT) || accept;
      result_valid = (state_q == DONE);
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
            WAIT: begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE)
                  state_d = DONE;
            end
            DONE: begin
               if (accept) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Operand magnitudes and sign at accept; signed product at capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ip_a   <= '0;
         ip_b   <= '0;
         neg    <= 1'b0;
         result <= '0;
      end else begin
         if (accept) begin
            ip_a <= magnitude(op1, is_signed);
            ip_b <= magnitude(op2, is_signed);
            neg  <= is_signed & (op1[DATA_W-1] ^ op2[DATA_W-1]);
         end
         if (capture)
            result <= apply_sign(ip_p, neg);
      end
   end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed bench for mult_ctrl with a behavioural
// LATENCY-stage unsigned multiplier standing in for the IP.
module tb_mult_ctrl;

   localparam int DW  = 32;
   localparam int LAT = 6;

   logic            clk;
   logic            rst;
   logic            start;
   logic            is_signed;
   logic [DW-1:0]   op1, op2;
   logic            flush;
   logic [DW-1:0]   ip_a, ip_b;
   logic [2*DW-1:0] ip_p;
   logic            stall_req;
   logic [2*DW-1:0] result;
   logic            result_valid;

   int checks = 0;
   int errors = 0;

   mult_ctrl #(.DATA_W(DW), .LATENCY(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .is_signed    (is_signed),
      .op1          (op1),
      .op2          (op2),
      .flush        (flush),
      .ip_a         (ip_a),
      .ip_b         (ip_b),
      .ip_p         (ip_p),
      .stall_req    (stall_req),
      .result       (result),
      .result_valid (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural IP: LAT-stage pipelined unsigned multiplier.
   logic [2*DW-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= {{DW{1'b0}}, ip_a} * {{DW{1'b0}}, ip_b};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ip_p = pipe[LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One isolated operation starting in the next cycle (cycle 0).
   task automatic do_op(input string tag, input logic sgn,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                        input logic [2*DW-1:0] exp);
      int stall_cnt;
      int vcycle;
      int nval;
      logic [2*DW-1:0] got;
      stall_cnt = 0; vcycle = -1; nval = 0; got = '0;
      @(posedge clk); #1;
      is_signed = sgn; op1 = a; op2 = b; start = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (stall_req) stall_cnt++;
         if (result_valid) begin
            nval++;
            if (vcycle < 0) begin
               vcycle = c;
               got = result;
            end
         end
         if (c == 3) begin
            check({tag, "_ip_a"}, 64'(ip_a), 64'(ea));
            check({tag, "_ip_b"}, 64'(ip_b), 64'(eb));
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check({tag, "_result"}, got, exp);
      check({tag, "_latency"}, 64'(vcycle), 64'd8);
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd8);
      check({tag, "_valid_count"}, 64'(nval), 64'd1);
   endtask

   initial begin
      logic [2*DW-1:0] held;
      int nval;
      int stall_cnt;
      logic v8, v16;
      logic [2*DW-1:0] got1, got2;

      rst = 1'b0; start = 1'b0; is_signed = 1'b0; op1 = '0; op2 = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ip_a", 64'(ip_a), 64'd0);
      check("reset_ip_b", 64'(ip_b), 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_valid", 64'(result_valid), 64'd0);
      check("reset_stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Unsigned max and signed products
      do_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'hFFFF_FFFE_0000_0001);
      do_op("m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1,
            64'h0000_0000_0000_0001);
      do_op("m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd3, 32'd5,
            64'hFFFF_FFFF_FFFF_FFF1);
      do_op("minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            64'h4000_0000_0000_0000);
      do_op("u_minx2", 1'b0, 32'h8000_0000, 32'd2, 32'h8000_0000, 32'd2,
            64'h0000_0001_0000_0000);

      // Flush mid-operation: start at cycle 0, flush in cycle 3
      held = result;
      nval = 0;
      @(posedge clk); #1;
      is_signed = 1'b0; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 4) check("flush_idle_stall", 64'(stall_req), 64'd0);
         if (c >= 4 && result_valid) nval++;
         @(posedge clk); #1;
         start = 1'b0;
         flush = (c + 1 == 3);
      end
      flush = 1'b0;
      check("flush_no_valid", 64'(nval), 64'd0);
      check("flush_result_held", result, held);

      // Reset mid-operation: rst low in cycle 4
      @(posedge clk); #1;
      is_signed = 1'b0; op1 = 32'd11; op2 = 32'd13; start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ip_a", 64'(ip_a), 64'd0);
      check("midrst_ip_b", 64'(ip_b), 64'd0);
      check("midrst_result", result, 64'd0);
      check("midrst_valid", 64'(result_valid), 64'd0);
      check("midrst_stall", 64'(stall_req), 64'd0);
      do_op("post_rst", 1'b0, 32'd11, 32'd13, 32'd11, 32'd13, 64'd143);

      // Chaining: 7x6 with start held through WAIT, then MULT -2x4 in DONE
      nval = 0; stall_cnt = 0; v8 = 1'b0; v16 = 1'b0; got1 = '0; got2 = '0;
      @(posedge clk); #1;
      is_signed = 1'b0; op1 = 32'd7; op2 = 32'd6; start = 1'b1;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (c <= 15 && stall_req) stall_cnt++;
         if (c == 16) check("chain_done_stall", 64'(stall_req), 64'd0);
         if (result_valid) begin
            nval++;
            if (c == 8)  begin v8 = 1'b1;  got1 = result; end
            if (c == 16) begin v16 = 1'b1; got2 = result; end
         end
         @(posedge clk); #1;
         if (c + 1 == 8) begin
            is_signed = 1'b1; op1 = 32'hFFFF_FFFE; op2 = 32'd4;
         end
         if (c + 1 == 9) start = 1'b0;
      end
      check("chain_first_valid", 64'(v8), 64'd1);
      check("chain_first_result", got1, 64'h2A);
      check("chain_second_valid", 64'(v16), 64'd1);
      check("chain_second_result", got2, 64'hFFFF_FFFF_FFFF_FFF8);
      check("chain_valid_count", 64'(nval), 64'd2);
      check("chain_stall_cycles", 64'(stall_cnt), 64'd16);

      // Start/flush collision in IDLE
      nval = 0;
      @(posedge clk); #1;
      is_signed = 1'b0; op1 = 32'd3; op2 = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("collide_stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (result_valid) nval++;
      end
      check("collide_no_valid", 64'(nval), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Bound total run time
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
